// File: rtl/rechteck_fueller.sv
// Rectangle-fill sequencer sharing one frame-buffer write port with CPU pixel writes.
// Optional RECHTECK_CLIP_EN clamps rectangles to the visible WIDTH x HEIGHT area.
module rechteck_fueller #(
  parameter int unsigned WIDTH        = 160,
  parameter int unsigned HEIGHT       = 120,
  parameter int unsigned BITSPERPIXEL = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_x0,
  input  logic [7:0]              cmd_y0,
  input  logic [7:0]              cmd_w,
  input  logic [7:0]              cmd_h,
  input  logic [BITSPERPIXEL-1:0] cmd_color,
  input  logic                    cpu_write,
  input  logic [7:0]              cpu_x,
  input  logic [7:0]              cpu_y,
  input  logic [BITSPERPIXEL-1:0] cpu_color,
  output logic [7:0]              x,
  output logic [7:0]              y,
  output logic [BITSPERPIXEL-1:0] color,
  output logic                    write,
  output logic                    busy,
  output logic                    done
);

  if ((WIDTH > 256) || (HEIGHT > 256) || (BITSPERPIXEL == 0)) begin : g_bad_cfg
    $error("rechteck_fueller: unsupported geometry");
  end

`ifdef RECHTECK_CLIP_EN
  localparam logic [8:0] XLim = 9'(WIDTH);
  localparam logic [8:0] YLim = 9'(HEIGHT);
  localparam logic [8:0] XMax = 9'(WIDTH - 1);
  localparam logic [8:0] YMax = 9'(HEIGHT - 1);
`endif

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                  state_q;
  logic [7:0]              x0_q;
  logic [8:0]              xend_q, yend_q;
  logic [8:0]              cur_x_q, cur_y_q;
  logic [BITSPERPIXEL-1:0] fill_color_q;
  logic                    drain_q;

  logic [7:0]              x_q, y_q;
  logic [BITSPERPIXEL-1:0] color_q;
  logic                    write_q, busy_q, done_q, ready_q;

  logic [8:0] xend_raw, yend_raw, xend_acc, yend_acc;
  logic       accept, empty, issue, last, on_grid;

  always_comb begin
    xend_raw = {1'b0, cmd_x0} + {1'b0, cmd_w} - 9'd1;
    yend_raw = {1'b0, cmd_y0} + {1'b0, cmd_h} - 9'd1;
`ifdef RECHTECK_CLIP_EN
    xend_acc = (xend_raw > XMax) ? XMax : xend_raw;
    yend_acc = (yend_raw > YMax) ? YMax : yend_raw;
    empty    = (cmd_w == 8'd0) || (cmd_h == 8'd0) ||
               ({1'b0, cmd_x0} >= XLim) || ({1'b0, cmd_y0} >= YLim);
`else
    xend_acc = xend_raw;
    yend_acc = yend_raw;
    empty    = (cmd_w == 8'd0) || (cmd_h == 8'd0);
`endif
    accept  = cmd_valid && ready_q;
    // CPU writes steal the cycle; the cursor simply holds.
    issue   = (state_q == StFill) && !drain_q && !cpu_write;
    last    = (cur_x_q == xend_q) && (cur_y_q == yend_q);
    // Coordinates past 255 consume their cycle but never reach the port.
    on_grid = !cur_x_q[8] && !cur_y_q[8];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      x0_q         <= '0;
      xend_q       <= '0;
      yend_q       <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      fill_color_q <= '0;
      drain_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      if (cpu_write) begin
        x_q     <= cpu_x;
        y_q     <= cpu_y;
        color_q <= cpu_color;
        write_q <= 1'b1;
      end else if (issue && on_grid) begin
        x_q     <= cur_x_q[7:0];
        y_q     <= cur_y_q[7:0];
        color_q <= fill_color_q;
        write_q <= 1'b1;
      end else begin
        write_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            x0_q         <= cmd_x0;
            xend_q       <= xend_acc;
            yend_q       <= yend_acc;
            cur_x_q      <= {1'b0, cmd_x0};
            cur_y_q      <= {1'b0, cmd_y0};
            fill_color_q <= cmd_color;
            drain_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            if (empty) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StFill: begin
          // One trailing cycle lets the last pixel reach the port before done.
          if (drain_q) begin
            drain_q <= 1'b0;
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (issue) begin
            if (last) begin
              drain_q <= 1'b1;
            end else if (cur_x_q == xend_q) begin
              cur_x_q <= {1'b0, x0_q};
              cur_y_q <= cur_y_q + 9'd1;
            end else begin
              cur_x_q <= cur_x_q + 9'd1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign color     = color_q;
  assign write     = write_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_rechteck_fueller.sv
// Directed self-checking bench for rechteck_fueller; honours RECHTECK_CLIP_EN when defined.
module tb_rechteck_fueller;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0, cmd_color = '0;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_x = '0, cpu_y = '0, cpu_color = '0;
  logic [7:0] x, y, color;
  logic       write, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  rechteck_fueller #(
    .WIDTH       (160),
    .HEIGHT      (120),
    .BITSPERPIXEL(8)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .cpu_write(cpu_write),
    .cpu_x    (cpu_x),
    .cpu_y    (cpu_y),
    .cpu_color(cpu_color),
    .x        (x),
    .y        (y),
    .color    (color),
    .write    (write),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of accept+1.
  task automatic issue_cmd(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                           input logic [7:0] h, input logic [7:0] col);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_errors++;
      $display("FAIL cmd_ready_timeout cmd_ready=%b required=1", cmd_ready);
    end
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = col;
    cmd_valid = 1'b1;
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int nw;
    #12;
    n_checks++;
    if (write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state write=%b busy=%b done=%b ready=%b required 0 0 0 1",
               write, busy, done, cmd_ready);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (write !== 1'b0) nw++;
    end
    n_checks++;
    if (nw != 0) begin
      n_errors++;
      $display("FAIL idle_no_writes write_cycles=%0d required=0", nw);
    end
  endtask

  task automatic test_fill_3x2();
    int idx;
    logic ew;
    issue_cmd(8'd10, 8'd5, 8'd3, 8'd2, 8'hA5);
    for (int k = 1; k <= 10; k++) begin
      idx = k - 2;
      ew  = (idx >= 0) && (idx < 6);
      n_checks++;
      if (write !== ew) begin
        n_errors++;
        $display("FAIL fill_write k=%0d write=%b required=%b", k, write, ew);
      end
      if (ew) begin
        n_checks++;
        if (x !== 8'(10 + idx % 3) || y !== 8'(5 + idx / 3) || color !== 8'hA5) begin
          n_errors++;
          $display("FAIL fill_pixel k=%0d got=(%0d,%0d,%h) required=(%0d,%0d,a5)",
                   k, x, y, color, 10 + idx % 3, 5 + idx / 3);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (x !== 8'd12 || y !== 8'd6) begin
          n_errors++;
          $display("FAIL fill_hold got=(%0d,%0d) required=(12,6)", x, y);
        end
      end
      n_checks++;
      if (done !== (k == 8) || busy !== (k <= 8) || cmd_ready !== (k >= 9)) begin
        n_errors++;
        $display("FAIL fill_ctrl k=%0d done=%b busy=%b ready=%b required %b %b %b",
                 k, done, busy, cmd_ready, (k == 8), (k <= 8), (k >= 9));
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_cpu_collision();
    int idx;
    logic ew;
    issue_cmd(8'd10, 8'd5, 8'd3, 8'd2, 8'hA5);
    for (int k = 1; k <= 11; k++) begin
      if (k == 3) begin
        n_checks++;
        if (write !== 1'b1 || x !== 8'd0 || y !== 8'd0 || color !== 8'h3C) begin
          n_errors++;
          $display("FAIL collision_cpu got=(%b,%0d,%0d,%h) required=(1,0,0,3c)",
                   write, x, y, color);
        end
      end else begin
        idx = (k < 3) ? k - 2 : k - 3;
        ew  = (idx >= 0) && (idx < 6);
        n_checks++;
        if (write !== ew ||
            (ew && (x !== 8'(10 + idx % 3) || y !== 8'(5 + idx / 3) || color !== 8'hA5))) begin
          n_errors++;
          $display("FAIL collision_pixel k=%0d got=(%b,%0d,%0d,%h) required write=%b",
                   k, write, x, y, color, ew);
        end
      end
      n_checks++;
      if (done !== (k == 9) || cmd_ready !== (k >= 10)) begin
        n_errors++;
        $display("FAIL collision_ctrl k=%0d done=%b ready=%b required %b %b",
                 k, done, cmd_ready, (k == 9), (k >= 10));
      end
      if (k == 2) begin
        cpu_write = 1'b1; cpu_x = 8'd0; cpu_y = 8'd0; cpu_color = 8'h3C;
      end else begin
        cpu_write = 1'b0;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_zero_size();
    issue_cmd(8'd20, 8'd20, 8'd0, 8'd7, 8'h55);
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (write !== 1'b0 || done !== (k == 1) || busy !== (k == 1) ||
          cmd_ready !== (k >= 2)) begin
        n_errors++;
        $display("FAIL zero_size k=%0d write=%b done=%b busy=%b ready=%b", k, write, done,
                 busy, cmd_ready);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_edge_rect();
    logic ew;
    int   dk;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) issue_cmd(8'd158, 8'd3, 8'd4, 8'd1, 8'h11);
`ifdef RECHTECK_CLIP_EN
      ew = (k >= 2) && (k <= 3);
      dk = 4;
`else
      ew = (k >= 2) && (k <= 5);
      dk = 6;
`endif
      n_checks++;
      if (write !== ew || (ew && (x !== 8'(156 + k) || y !== 8'd3 || color !== 8'h11))) begin
        n_errors++;
        $display("FAIL edge_pixel k=%0d got=(%b,%0d,%0d,%h) required write=%b x=%0d",
                 k, write, x, y, color, ew, 156 + k);
      end
      n_checks++;
      if (done !== (k == dk)) begin
        n_errors++;
        $display("FAIL edge_done k=%0d done=%b required=%b", k, done, (k == dk));
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_wrap_suppress();
    logic ew;
    int   dk;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) issue_cmd(8'd254, 8'd3, 8'd4, 8'd1, 8'h22);
`ifdef RECHTECK_CLIP_EN
      ew = 1'b0;
      dk = 1;
`else
      ew = (k >= 2) && (k <= 3);
      dk = 6;
      if (k == 4 || k == 5) begin
        n_checks++;
        if (x !== 8'd255 || y !== 8'd3) begin
          n_errors++;
          $display("FAIL wrap_hold k=%0d got=(%0d,%0d) required=(255,3)", k, x, y);
        end
      end
`endif
      n_checks++;
      if (write !== ew || (ew && (x !== 8'(252 + k) || color !== 8'h22))) begin
        n_errors++;
        $display("FAIL wrap_pixel k=%0d got=(%b,%0d,%h) required write=%b", k, write, x, color,
                 ew);
      end
      n_checks++;
      if (done !== (k == dk)) begin
        n_errors++;
        $display("FAIL wrap_done k=%0d done=%b required=%b", k, done, (k == dk));
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_cpu_idle();
    cpu_write = 1'b1; cpu_x = 8'd7; cpu_y = 8'd9; cpu_color = 8'h77;
    @(negedge clk_in);
    cpu_write = 1'b0;
    n_checks++;
    if (write !== 1'b1 || x !== 8'd7 || y !== 8'd9 || color !== 8'h77 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL cpu_idle got=(%b,%0d,%0d,%h) busy=%b required=(1,7,9,77) busy=0",
               write, x, y, color, busy);
    end
    @(negedge clk_in);
    n_checks++;
    if (write !== 1'b0 || x !== 8'd7 || y !== 8'd9) begin
      n_errors++;
      $display("FAIL cpu_idle_after got=(%b,%0d,%0d) required=(0,7,9)", write, x, y);
    end
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    issue_cmd(8'd0, 8'd0, 8'd10, 8'd10, 8'h99);
    for (int k = 1; k <= 3; k++) @(negedge clk_in);
    n_checks++;
    if (write !== 1'b1 || x !== 8'd2 || y !== 8'd0) begin
      n_errors++;
      $display("FAIL midfill_third got=(%b,%0d,%0d) required=(1,2,0)", write, x, y);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midfill_reset write=%b busy=%b done=%b ready=%b required 0 0 0 1",
               write, busy, done, cmd_ready);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      if (write !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midfill_after bad_cycles=%0d ready=%b required 0 1", bad, cmd_ready);
    end
    issue_cmd(8'd40, 8'd50, 8'd1, 8'd1, 8'hC3);
    @(negedge clk_in);
    n_checks++;
    if (write !== 1'b1 || x !== 8'd40 || y !== 8'd50 || color !== 8'hC3) begin
      n_errors++;
      $display("FAIL midfill_newcmd got=(%b,%0d,%0d,%h) required=(1,40,50,c3)",
               write, x, y, color);
    end
    @(negedge clk_in);
    n_checks++;
    if (done !== 1'b1 || write !== 1'b0) begin
      n_errors++;
      $display("FAIL midfill_newdone done=%b write=%b required 1 0", done, write);
    end
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_fill_3x2();
    test_cpu_collision();
    test_zero_size();
    test_edge_rect();
    test_wrap_suppress();
    test_cpu_idle();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rechteck_fueller.md
# rechteck_fueller

Rectangle-fill controller in front of the 160×120, 8-bit frame buffer write port. It accepts rectangle fill commands, sequences them into one pixel write per clock, and shares the single write port with direct CPU pixel writes; CPU writes always take priority. It sits between the processor/GPU command side and the frame buffer, in the `clk_in` domain.

## Interface
- `WIDTH`, 160, visible columns.
- `HEIGHT`, 120, visible rows.
- `BITSPERPIXEL`, 8, colour width.

Ports:
- `clk_in` in 1: processor/GPU clock. One clock only.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: fill command offered.
- `cmd_ready` out 1: high in IDLE only. Reset value 1.
- `cmd_x0`, `cmd_y0` in 8 each: top-left corner.
- `cmd_w`, `cmd_h` in 8 each: width and height in pixels. 0 is legal.
- `cmd_color` in BITSPERPIXEL: fill colour.
- `cpu_write` in 1: single-pixel write request. Never back-pressured.
- `cpu_x`, `cpu_y` in 8 each; `cpu_color` in BITSPERPIXEL: CPU pixel.
- `x`, `y` out 8 each; `color` out BITSPERPIXEL; `write` out 1: registered frame buffer write port. Reset value 0.
- `busy` out 1: high in FILL and DONE. Reset value 0.
- `done` out 1: one-cycle pulse at end of command. Reset value 0.

## Operation
- States are IDLE, FILL and DONE.
- **IDLE**
  - Command accepted on `cmd_valid && cmd_ready`.
  - Accepting latches x0, y0, w, h and colour, and sets the cursor to (x0, y0).
  - If `w == 0` or `h == 0`, go to DONE without issuing any write. Otherwise go to FILL.
- **FILL**
  - Each cycle without `cpu_write`, the cursor pixel is issued and the cursor advances.
  - Scan order is row-major: x increments; at x = xend, x reloads x0 and y increments.
  - After pixel (xend, yend) is issued, go to DONE.
- **DONE**
  - `done = 1` for exactly one cycle, then IDLE.
  - `cmd_ready` stays low in DONE.
- **Arithmetic**
  - xend = x0 + w − 1 and yend = y0 + h − 1, computed at 9 bits.
  - The cursor is 9 bits wide. Coordinates ≥ 256 never wrap into 0–255.
- **Arbitration**
  - `cpu_write` wins unconditionally.
  - When it is high, the next output cycle carries the CPU pixel and the fill cursor holds.
  - CPU writes are forwarded in every state, including IDLE.
- **Reset mid-operation:** return to IDLE. Pending fill is discarded, no `done` pulse.

## Timing
- Outputs `x`, `y`, `color` and `write` are registered: a request in cycle N appears on the port in cycle N+1.
- CPU write at cycle N appears with `write = 1` in cycle N+1.
- Command accepted at cycle N:
  - FILL is entered at N+1.
  - The first fill pixel is on the port in cycle N+2.
- Throughput is 1 pixel/cycle. The total FILL duration is w·h cycles plus one cycle per overlapping `cpu_write`.
- `done` is asserted in the cycle after the last fill pixel's output cycle.
- `cmd_ready` rises in the cycle after `done`, so back-to-back commands have a 1-cycle gap.
- Zero-size command: `done` in cycle N+1, no `write`.
- When the output cycle carries neither a CPU pixel nor a fill pixel, `write = 0` and `x`, `y`, `color` hold their previous values.

## Configuration
- `RECHTECK_CLIP_EN` defined:
  - On acceptance, xend is clamped to min(xend, WIDTH−1) and yend to min(yend, HEIGHT−1).
  - A rectangle with x0 ≥ WIDTH or y0 ≥ HEIGHT goes directly to DONE with zero writes.
  - Off-screen cycles are never spent.
- Not defined:
  - The full w·h cursor sweep runs.
  - Pixels with a 9-bit coordinate ≥ 256 are suppressed (`write = 0`) but still consume their cycle.
  - Pixels in 160–255 are issued, and the frame buffer discards them.

## Test plan
- **Reset:** `rst_n` low → `write = 0`, `busy = 0`, `done = 0`, `cmd_ready = 1`. Release with no stimulus → no writes for 20 cycles.
- **3×2 fill:** x0 = 10, y0 = 5, colour 0xA5 → writes in order (10,5), (11,5), (12,5), (10,6), (11,6), (12,6), all colour 0xA5, in 6 consecutive cycles starting at accept+2. `done` at accept+8.
- **CPU collision:** `cpu_write` (0,0, 0x3C) pulsed during the 2nd pixel of the 3×2 fill → the port shows (0,0, 0x3C) that cycle. Fill resumes without skipping a pixel. `done` is one cycle later than the undisturbed case.
- **Zero size:** w = 0, h = 7 → no `write`, `done` at accept+1, `cmd_ready` back at accept+2.
- **Edge rectangle:** x0 = 158, w = 4, h = 1.
  - With `RECHTECK_CLIP_EN`: exactly 2 writes, (158,y) and (159,y).
  - Without: 4 write cycles covering x = 158–161.
- **Reset mid-fill:** `rst_n` low during the 3rd pixel of a 10×10 fill → `write` drops immediately, no `done`. After release, `cmd_ready = 1` and a new command is accepted.
